// File: rtl/subsystem_ctrl.sv
// Command sequencer for the regfile+ALU subsystem: expands ALU/LOADI commands into
// read/execute/write-back strobes, tracks a sticky overflow flag and a retire count.
module subsystem_ctrl #(
   parameter int AddrSize  = 6,
   parameter int DataSize  = 32,
   parameter int ALUopSize = 4,
   parameter int CntSize   = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_type,
   input  logic [ALUopSize-1:0] cmd_op,
   input  logic [AddrSize-1:0]  cmd_dst,
   input  logic [AddrSize-1:0]  cmd_src1,
   input  logic [AddrSize-1:0]  cmd_src2,
   input  logic [DataSize-1:0]  cmd_imm,
   output logic                 reg_enable,
   output logic                 reg_write,
   output logic [AddrSize-1:0]  src1_addr,
   output logic [AddrSize-1:0]  src2_addr,
   output logic [AddrSize-1:0]  write_addr,
   output logic [DataSize-1:0]  write_data,
   output logic                 write_sel,
   output logic                 alu_enable,
   output logic [ALUopSize-1:0] alu_op,
   input  logic                 alu_overflow,
   input  logic                 ovf_clr,
   output logic                 ovf_flag,
   output logic                 done,
   output logic [CntSize-1:0]   retire_cnt
);

   typedef enum logic [2:0] {IDLE, READ, EXEC, WSETUP, WCOMMIT} state_t;

   state_t state, state_nxt;

   logic                 type_q;
   logic [AddrSize-1:0]  dst_q;
   logic [ALUopSize-1:0] op_q;

   logic                 accept;
   logic                 reg_enable_nxt, reg_write_nxt, write_sel_nxt, alu_enable_nxt, done_nxt;
   logic [AddrSize-1:0]  src1_nxt, src2_nxt, waddr_nxt;
   logic [DataSize-1:0]  wdata_nxt;
   logic [ALUopSize-1:0] op_nxt;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid & cmd_ready;

   // Outputs are computed for the state being entered, then registered with it.
   always_comb begin
      state_nxt      = state;
      reg_enable_nxt = 1'b0;
      reg_write_nxt  = 1'b0;
      write_sel_nxt  = 1'b0;
      alu_enable_nxt = 1'b0;
      done_nxt       = 1'b0;
      src1_nxt       = src1_addr;
      src2_nxt       = src2_addr;
      waddr_nxt      = write_addr;
      wdata_nxt      = write_data;
      op_nxt         = alu_op;
      case (state)
         IDLE: begin
            if (accept) begin
               reg_enable_nxt = 1'b1;
               if (cmd_type) begin
                  state_nxt = READ;
                  src1_nxt  = cmd_src1;
                  src2_nxt  = cmd_src2;
               end else begin
                  state_nxt = WSETUP;
                  waddr_nxt = cmd_dst;
                  wdata_nxt = cmd_imm;
               end
            end
         end
         READ: begin
            state_nxt      = EXEC;
            reg_enable_nxt = 1'b1;
            alu_enable_nxt = 1'b1;
            op_nxt         = op_q;
         end
         EXEC: begin
            state_nxt      = WSETUP;
            reg_enable_nxt = 1'b1;
            alu_enable_nxt = 1'b1;
            write_sel_nxt  = 1'b1;
            waddr_nxt      = dst_q;
         end
         WSETUP: begin
            state_nxt      = WCOMMIT;
            reg_enable_nxt = 1'b1;
            reg_write_nxt  = 1'b1;
            alu_enable_nxt = type_q;
            write_sel_nxt  = type_q;
         end
         WCOMMIT: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         type_q     <= 1'b0;
         dst_q      <= '0;
         op_q       <= '0;
         reg_enable <= 1'b0;
         reg_write  <= 1'b0;
         write_sel  <= 1'b0;
         alu_enable <= 1'b0;
         done       <= 1'b0;
         src1_addr  <= '0;
         src2_addr  <= '0;
         write_addr <= '0;
         write_data <= '0;
         alu_op     <= '0;
      end else begin
         state      <= state_nxt;
         reg_enable <= reg_enable_nxt;
         reg_write  <= reg_write_nxt;
         write_sel  <= write_sel_nxt;
         alu_enable <= alu_enable_nxt;
         done       <= done_nxt;
         src1_addr  <= src1_nxt;
         src2_addr  <= src2_nxt;
         write_addr <= waddr_nxt;
         write_data <= wdata_nxt;
         alu_op     <= op_nxt;
         if (accept) begin
            type_q <= cmd_type;
            dst_q  <= cmd_dst;
            op_q   <= cmd_op;
         end
      end
   end

   // Overflow is only meaningful on the edge that ends EXEC; a set beats a clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_flag   <= 1'b0;
         retire_cnt <= '0;
      end else begin
         if ((state == EXEC) && alu_overflow) ovf_flag <= 1'b1;
         else if (ovf_clr)                    ovf_flag <= 1'b0;
         if (state == WCOMMIT) retire_cnt <= retire_cnt + {{(CntSize-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: tb/tb_subsystem_ctrl.sv
// Directed bench for subsystem_ctrl: reset, LOADI, ALU sequencing, overflow flag,
// back-to-back commands, abort by reset and retire counter wrap.
module tb_subsystem_ctrl;
   localparam int AW = 6, DW = 32, OW = 4, CW = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          cmd_valid, cmd_ready, cmd_type;
   logic [OW-1:0] cmd_op;
   logic [AW-1:0] cmd_dst, cmd_src1, cmd_src2;
   logic [DW-1:0] cmd_imm;
   logic          reg_enable, reg_write, write_sel, alu_enable;
   logic [AW-1:0] src1_addr, src2_addr, write_addr;
   logic [DW-1:0] write_data;
   logic [OW-1:0] alu_op;
   logic          alu_overflow, ovf_clr, ovf_flag, done;
   logic [CW-1:0] retire_cnt;

   int passes = 0, fails = 0, total = 0;
   int n, wr_cnt, done_cnt;
   logic [12:0] rdy_pat;
   logic seen;

   subsystem_ctrl #(.AddrSize(AW), .DataSize(DW), .ALUopSize(OW), .CntSize(CW)) dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_type(cmd_type), .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_src1(cmd_src1),
      .cmd_src2(cmd_src2), .cmd_imm(cmd_imm), .reg_enable(reg_enable),
      .reg_write(reg_write), .src1_addr(src1_addr), .src2_addr(src2_addr),
      .write_addr(write_addr), .write_data(write_data), .write_sel(write_sel),
      .alu_enable(alu_enable), .alu_op(alu_op), .alu_overflow(alu_overflow),
      .ovf_clr(ovf_clr), .ovf_flag(ovf_flag), .done(done), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the first busy cycle.
   task automatic send(input logic t, input logic [OW-1:0] op, input logic [AW-1:0] dst,
                       input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [DW-1:0] imm);
      cmd_type = t; cmd_op = op; cmd_dst = dst; cmd_src1 = s1; cmd_src2 = s2; cmd_imm = imm;
      cmd_valid = 1'b1;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_type = 1'b0; cmd_op = '0; cmd_dst = '0;
      cmd_src1 = '0; cmd_src2 = '0; cmd_imm = '0; alu_overflow = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_ready", 64'(cmd_ready), 64'(1));
      chk("rst_reg_en", 64'(reg_enable), 64'(0));
      chk("rst_reg_wr", 64'(reg_write), 64'(0));
      chk("rst_src1", 64'(src1_addr), 64'(0));
      chk("rst_src2", 64'(src2_addr), 64'(0));
      chk("rst_waddr", 64'(write_addr), 64'(0));
      chk("rst_wdata", 64'(write_data), 64'(0));
      chk("rst_wsel", 64'(write_sel), 64'(0));
      chk("rst_alu_en", 64'(alu_enable), 64'(0));
      chk("rst_alu_op", 64'(alu_op), 64'(0));
      chk("rst_ovf", 64'(ovf_flag), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_cnt", 64'(retire_cnt), 64'(0));
      rst = 1'b1;
      @(negedge clk);

      // LOADI dst=5
      send(1'b0, 4'hF, 6'd5, 6'd1, 6'd1, 32'hDEADBEEF);
      chk("li_ws_ready", 64'(cmd_ready), 64'(0));
      chk("li_ws_en", 64'(reg_enable), 64'(1));
      chk("li_ws_wr", 64'(reg_write), 64'(0));
      chk("li_ws_wsel", 64'(write_sel), 64'(0));
      chk("li_ws_waddr", 64'(write_addr), 64'(5));
      chk("li_ws_wdata", 64'(write_data), 64'(32'hDEADBEEF));
      chk("li_ws_alu_en", 64'(alu_enable), 64'(0));
      @(negedge clk);
      chk("li_wc_wr", 64'(reg_write), 64'(1));
      chk("li_wc_wsel", 64'(write_sel), 64'(0));
      chk("li_wc_waddr", 64'(write_addr), 64'(5));
      chk("li_wc_done", 64'(done), 64'(0));
      @(negedge clk);
      chk("li_done", 64'(done), 64'(1));
      chk("li_cnt", 64'(retire_cnt), 64'(1));
      chk("li_idle_wr", 64'(reg_write), 64'(0));
      chk("li_idle_en", 64'(reg_enable), 64'(0));
      chk("li_idle_ready", 64'(cmd_ready), 64'(1));
      chk("li_hold_wdata", 64'(write_data), 64'(32'hDEADBEEF));
      @(negedge clk);
      chk("li_done_pulse", 64'(done), 64'(0));

      // ALU op=3 src1=1 src2=2 dst=3
      send(1'b1, 4'h3, 6'd3, 6'd1, 6'd2, 32'h0);
      chk("alu_rd_ready", 64'(cmd_ready), 64'(0));
      chk("alu_rd_en", 64'(reg_enable), 64'(1));
      chk("alu_rd_src1", 64'(src1_addr), 64'(1));
      chk("alu_rd_src2", 64'(src2_addr), 64'(2));
      chk("alu_rd_alu_en", 64'(alu_enable), 64'(0));
      @(negedge clk);
      chk("alu_ex_alu_en", 64'(alu_enable), 64'(1));
      chk("alu_ex_op", 64'(alu_op), 64'(3));
      chk("alu_ex_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      chk("alu_ws_wsel", 64'(write_sel), 64'(1));
      chk("alu_ws_waddr", 64'(write_addr), 64'(3));
      chk("alu_ws_alu_en", 64'(alu_enable), 64'(1));
      chk("alu_ws_wr", 64'(reg_write), 64'(0));
      @(negedge clk);
      chk("alu_wc_wr", 64'(reg_write), 64'(1));
      chk("alu_wc_wsel", 64'(write_sel), 64'(1));
      chk("alu_wc_ready", 64'(cmd_ready), 64'(0));
      @(negedge clk);
      chk("alu_done", 64'(done), 64'(1));
      chk("alu_cnt", 64'(retire_cnt), 64'(2));
      chk("alu_ready", 64'(cmd_ready), 64'(1));
      chk("alu_hold_src1", 64'(src1_addr), 64'(1));
      chk("alu_ovf0", 64'(ovf_flag), 64'(0));

      // Overflow raised from READ onward: only the EXEC sample counts
      send(1'b1, 4'h1, 6'd6, 6'd4, 6'd5, 32'h0);
      alu_overflow = 1'b1;
      @(negedge clk);
      chk("ovf_read_ignored", 64'(ovf_flag), 64'(0));
      @(negedge clk);
      chk("ovf_set", 64'(ovf_flag), 64'(1));
      alu_overflow = 1'b0;
      repeat (2) @(negedge clk);
      chk("ovf_cnt3", 64'(retire_cnt), 64'(3));
      send(1'b0, 4'h0, 6'd7, 6'd0, 6'd0, 32'h1);
      repeat (2) @(negedge clk);
      chk("ovf_after_loadi", 64'(ovf_flag), 64'(1));
      chk("ovf_cnt4", 64'(retire_cnt), 64'(4));
      send(1'b1, 4'h2, 6'd8, 6'd9, 6'd10, 32'h0);
      @(negedge clk);
      alu_overflow = 1'b1; ovf_clr = 1'b1;
      @(negedge clk);
      chk("ovf_set_wins", 64'(ovf_flag), 64'(1));
      alu_overflow = 1'b0; ovf_clr = 1'b0;
      repeat (2) @(negedge clk);
      chk("ovf_cnt5", 64'(retire_cnt), 64'(5));
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", 64'(ovf_flag), 64'(0));
      alu_overflow = 1'b1;
      repeat (2) @(negedge clk);
      alu_overflow = 1'b0;
      chk("ovf_idle_ignored", 64'(ovf_flag), 64'(0));

      // Back-to-back: ALU, LOADI, ALU with cmd_valid held high
      cmd_type = 1'b1; cmd_op = 4'hA; cmd_dst = 6'd10; cmd_src1 = 6'd8; cmd_src2 = 6'd9;
      cmd_imm = 32'h0; cmd_valid = 1'b1;
      rdy_pat = '0; wr_cnt = 0; done_cnt = 0;
      for (int i = 1; i <= 13; i++) begin
         @(negedge clk);
         rdy_pat[i-1] = cmd_ready;
         wr_cnt += int'(reg_write);
         done_cnt += int'(done);
         if (i == 5) begin
            cmd_type = 1'b0; cmd_dst = 6'd11; cmd_imm = 32'hCAFE0001;
         end
         if (i == 7) chk("b2b_li_wdata", 64'(write_data), 64'(32'hCAFE0001));
         if (i == 8) begin
            cmd_type = 1'b1; cmd_op = 4'h6; cmd_dst = 6'd12; cmd_src1 = 6'd13; cmd_src2 = 6'd14;
         end
         if (i == 9) chk("b2b_alu2_src1", 64'(src1_addr), 64'(13));
         if (i == 13) cmd_valid = 1'b0;
      end
      chk("b2b_ready_pattern", 64'(rdy_pat), 64'(13'h1090));
      chk("b2b_writes", 64'(wr_cnt), 64'(3));
      chk("b2b_dones", 64'(done_cnt), 64'(3));
      chk("b2b_cnt", 64'(retire_cnt), 64'(8));
      chk("b2b_waddr", 64'(write_addr), 64'(12));
      chk("b2b_wdata_hold", 64'(write_data), 64'(32'hCAFE0001));

      // Abort an ALU command in WSETUP
      send(1'b1, 4'h5, 6'd20, 6'd21, 6'd22, 32'h0);
      repeat (2) @(negedge clk);
      chk("abort_pre_waddr", 64'(write_addr), 64'(20));
      rst = 1'b0;
      #1;
      chk("abort_wr", 64'(reg_write), 64'(0));
      chk("abort_en", 64'(reg_enable), 64'(0));
      chk("abort_ready", 64'(cmd_ready), 64'(1));
      chk("abort_waddr", 64'(write_addr), 64'(0));
      chk("abort_alu_en", 64'(alu_enable), 64'(0));
      chk("abort_wsel", 64'(write_sel), 64'(0));
      chk("abort_cnt", 64'(retire_cnt), 64'(0));
      seen = 1'b0;
      repeat (3) begin @(negedge clk); seen |= reg_write; end
      rst = 1'b1;
      repeat (3) begin @(negedge clk); seen |= reg_write; end
      chk("abort_no_write", 64'(seen), 64'(0));
      chk("abort_cnt_after", 64'(retire_cnt), 64'(0));
      chk("abort_no_done", 64'(done), 64'(0));
      send(1'b0, 4'h0, 6'd0, 6'd0, 6'd0, 32'h12345678);
      @(negedge clk);
      chk("post_wc_wr", 64'(reg_write), 64'(1));
      chk("post_wc_waddr", 64'(write_addr), 64'(0));
      chk("post_wc_wdata", 64'(write_data), 64'(32'h12345678));
      @(negedge clk);
      chk("post_done", 64'(done), 64'(1));
      chk("post_cnt", 64'(retire_cnt), 64'(1));

      // Reset during WCOMMIT drops reg_write at once
      send(1'b0, 4'h0, 6'd9, 6'd0, 6'd0, 32'h55);
      @(negedge clk);
      chk("midrst_pre_wr", 64'(reg_write), 64'(1));
      rst = 1'b0;
      #1;
      chk("midrst_wr", 64'(reg_write), 64'(0));
      chk("midrst_cnt", 64'(retire_cnt), 64'(0));
      chk("midrst_wdata", 64'(write_data), 64'(0));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_no_done", 64'(done), 64'(0));
      chk("midrst_cnt_after", 64'(retire_cnt), 64'(0));

      // Counter wrap: 2^CW LOADI commands back to back
      cmd_type = 1'b0; cmd_dst = 6'd1; cmd_imm = 32'h0; cmd_valid = 1'b1;
      n = 0;
      for (int c = 0; c < 2000 && n < 256; c++) begin
         @(negedge clk);
         if (done) begin
            n++;
            if (n == 255) chk("wrap_max", 64'(retire_cnt), 64'(8'hFF));
            if (n == 256) cmd_valid = 1'b0;
         end
      end
      cmd_valid = 1'b0;
      chk("wrap_done_count", 64'(n), 64'(256));
      chk("wrap_zero", 64'(retire_cnt), 64'(0));
      @(negedge clk);
      chk("wrap_idle_ready", 64'(cmd_ready), 64'(1));

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end
endmodule
